// File: rtl/noc_pkg.sv
// Shared NoC spike-bus constants and helpers, imported by both bus ends
// so that the node count and the address width agree.
package noc_pkg;

   localparam int NOC_NUM_NODES  = 4;
   localparam int NOC_ADDR_WIDTH = 2;
   localparam int NOC_FIFO_DEPTH = 8;
   // One AER beat carries exactly one source address.
   localparam int AER_WIDTH      = NOC_ADDR_WIDTH;
   localparam int DROP_CNT_WIDTH = 16;

   // Ceiling log2, for elaboration-time sizing only.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int v = n - 1; v > 0; v = v >> 1) r++;
      return r;
   endfunction

endpackage

// File: rtl/noc_rx_fifo.sv
// Synchronous first-word-fall-through FIFO for AER beats.
// Full/empty are derived from the occupancy level; pointers wrap naturally
// because DEPTH is a power of two.
module noc_rx_fifo
   import noc_pkg::*;
#(
   parameter  int WIDTH = AER_WIDTH,
   parameter  int DEPTH = NOC_FIFO_DEPTH,
   localparam int PW    = clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] data_in,
   input  logic             pop,
   output logic [WIDTH-1:0] data_out,
   output logic             empty,
   output logic             full,
   output logic [PW:0]      level
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty    = (level == '0);
   assign full     = (level == (PW+1)'(DEPTH));
   assign do_pop   = pop && !empty;
   // A push into a full FIFO is accepted only when a pop frees a slot this cycle.
   assign do_push  = push && (!full || do_pop);
   assign data_out = empty ? '0 : mem[rd_ptr];

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   // Storage write.
   always_ff @(posedge clk) begin
      // NOTE: the storage array is deliberately not reset; an entry is only
      // ever read while the level says it holds valid data.
      if (do_push) mem[wr_ptr] <= data_in;
   end

endmodule

// File: rtl/noc_spike_rx.sv
// Receive end of the NoC spike bus: latches per-source spikes into pending
// bits, arbitrates them round-robin into an AER FIFO and presents one source
// address per beat on a valid/ready interface.
// Optional feature: define NOC_RX_DROP_CNT_EN to build the saturating
// merged-spike counter; otherwise drop_count is tied to zero.
module noc_spike_rx
   import noc_pkg::*;
#(
   parameter  int NUM_NODES  = NOC_NUM_NODES,
   parameter  int ADDR_WIDTH = NOC_ADDR_WIDTH,
   parameter  int FIFO_DEPTH = NOC_FIFO_DEPTH,
   localparam int LVL_W      = clog2(FIFO_DEPTH) + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_NODES-1:0]  spike_in,
   output logic                  aer_valid,
   output logic [ADDR_WIDTH-1:0] aer_addr,
   input  logic                  aer_ready,
   output logic                  pending_any,
   output logic [LVL_W-1:0]      fifo_level,
   output logic                  merge_pulse,
   output logic [15:0]           drop_count
);

   logic [NUM_NODES-1:0]  pending;
   logic [NUM_NODES-1:0]  grant;
   logic [NUM_NODES-1:0]  merged;
   logic [ADDR_WIDTH-1:0] last;
   logic [ADDR_WIDTH-1:0] grant_idx;
   logic                  grant_vld;
   logic                  fifo_empty;
   logic                  fifo_full;
   logic                  pop;
   logic                  can_grant;
   int                    idx;

   assign aer_valid   = !fifo_empty;
   assign pop         = aer_valid && aer_ready;
   assign can_grant   = !fifo_full || pop;
   assign pending_any = |pending;
   // A spike landing on a bit that is still pending and not granted is lost.
   assign merged      = spike_in & pending & ~grant;

   // Round-robin arbiter: rotate so the search starts at last+1, take the
   // first set bit, then map the rotated position back to a node index.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned and no latch is inferred.
      grant     = '0;
      grant_vld = 1'b0;
      grant_idx = '0;
      idx       = 0;
      for (int k = 0; k < NUM_NODES; k++) begin
         idx = (int'(last) + 1 + k) % NUM_NODES;
         if (!grant_vld && can_grant && pending[idx]) begin
            grant_vld = 1'b1;
            grant_idx = ADDR_WIDTH'(idx);
         end
      end
      if (grant_vld) grant[grant_idx] = 1'b1;
   end

   // Pending capture, round-robin pointer and merge flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending     <= '0;
         last        <= ADDR_WIDTH'(NUM_NODES - 1);
         merge_pulse <= 1'b0;
      end else begin
         // A new spike on a just-granted bit is a distinct event and re-arms it.
         pending     <= (pending & ~grant) | spike_in;
         if (grant_vld) last <= grant_idx;
         merge_pulse <= |merged;
      end
   end

`ifdef NOC_RX_DROP_CNT_EN
   logic [ADDR_WIDTH:0]     merged_cnt;
   logic [DROP_CNT_WIDTH:0] drop_sum;

   // Popcount of merged bits and saturating sum.
   always_comb begin
      merged_cnt = '0;
      for (int i = 0; i < NUM_NODES; i++) begin
         merged_cnt = merged_cnt + (ADDR_WIDTH+1)'(merged[i]);
      end
      drop_sum = {1'b0, drop_count} + (DROP_CNT_WIDTH+1)'(merged_cnt);
   end

   // Merged-spike counter, saturating at all ones.
   always_ff @(posedge clk) begin
      if (rst) begin
         drop_count <= '0;
      end else if (drop_sum[DROP_CNT_WIDTH]) begin
         drop_count <= '1;
      end else begin
         drop_count <= drop_sum[DROP_CNT_WIDTH-1:0];
      end
   end
`else
   assign drop_count = '0;
`endif

   noc_rx_fifo #(
      .WIDTH (ADDR_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (grant_vld),
      .data_in  (grant_idx),
      .pop      (pop),
      .data_out (aer_addr),
      .empty    (fifo_empty),
      .full     (fifo_full),
      .level    (fifo_level)
   );

endmodule

// File: tb/tb_noc_spike_rx.sv
// Self-checking bench for noc_spike_rx: table of single-cycle spike patterns
// plus hand-written backpressure, merge and mid-stream reset sequences.
// Expected beat addresses go into a scoreboard queue when stimulus is driven
// and are compared against aer_addr whenever aer_valid is high.
module tb_noc_spike_rx;

   localparam int N  = 4;
   localparam int AW = 2;
   localparam int LW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  spike_in;
   logic          aer_valid;
   logic [AW-1:0] aer_addr;
   logic          aer_ready;
   logic          pending_any;
   logic [LW-1:0] fifo_level;
   logic          merge_pulse;
   logic [15:0]   drop_count;

   int            n_checks = 0;
   int            n_errors = 0;
   logic [AW-1:0] sb [$];
   bit            mon_en = 1'b0;
   int            merge_seen = 0;

   typedef struct {
      logic [N-1:0] spike;
      int           n;
      logic [7:0]   addrs;   // beat k address in addrs[2k +: 2]
   } vec_t;

   vec_t tbl [7];

   always #5 clk = ~clk;

   noc_spike_rx dut (
      .clk         (clk),
      .rst         (rst),
      .spike_in    (spike_in),
      .aer_valid   (aer_valid),
      .aer_addr    (aer_addr),
      .aer_ready   (aer_ready),
      .pending_any (pending_any),
      .fifo_level  (fifo_level),
      .merge_pulse (merge_pulse),
      .drop_count  (drop_count)
   );

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
      n_checks++;
      if (actual !== required) begin
         n_errors++;
         $display("FAIL %s: got %0d, required %0d", name, actual, required);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset(input int cycles);
      rst = 1'b1;
      spike_in = '0;
      repeat (cycles) tick();
      rst = 1'b0;
      sb.delete();
   endtask

   task automatic push_batch();
      for (int a = 0; a < N; a++) sb.push_back(AW'(a));
   endtask

   task automatic wait_drain(input string name, input int limit);
      int c;
      c = 0;
      while ((sb.size() != 0 || aer_valid || pending_any) && c < limit) begin
         tick();
         c++;
      end
      check({name, "_drained"}, sb.size(), 0);
      check({name, "_level0"}, fifo_level, 0);
   endtask

   // Scoreboard monitor: head of queue must be on aer_addr for every valid
   // cycle, so a stalled beat is held against the same expected address.
   always @(negedge clk) begin
      if (merge_pulse === 1'b1) merge_seen++;
      if (mon_en && rst === 1'b0 && aer_valid === 1'b1) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_beat: got addr %0d, required no beat", aer_addr);
         end else begin
            check("beat_addr", aer_addr, sb[0]);
            if (aer_ready) void'(sb.pop_front());
         end
      end
   end

   initial begin
      int beats;
      int c;
      logic [15:0] exp_drop;

`ifdef NOC_RX_DROP_CNT_EN
      exp_drop = 16'd1;
`else
      exp_drop = 16'd0;
`endif

      tbl[0] = '{4'b1111, 4, 8'b11_10_01_00};  // 0,1,2,3 (first after reset)
      tbl[1] = '{4'b0100, 1, 8'b00_00_00_10};  // 2
      tbl[2] = '{4'b1001, 2, 8'b00_00_00_11};  // 3,0
      tbl[3] = '{4'b0110, 2, 8'b00_00_10_01};  // 1,2
      tbl[4] = '{4'b0011, 2, 8'b00_00_01_00};  // 0,1
      tbl[5] = '{4'b1010, 2, 8'b00_00_01_11};  // 3,1
      tbl[6] = '{4'b0001, 1, 8'b00_00_00_00};  // 0

      // Reset with random bus activity: everything must read zero.
      rst       = 1'b1;
      aer_ready = 1'b0;
      spike_in  = '0;
      repeat (3) begin
         spike_in = N'($urandom_range(0, 15));
         tick();
      end
      check("rst_valid",   aer_valid,   0);
      check("rst_addr",    aer_addr,    0);
      check("rst_pending", pending_any, 0);
      check("rst_level",   fifo_level,  0);
      check("rst_merge",   merge_pulse, 0);
      check("rst_drop",    drop_count,  0);
      spike_in = '0;
      rst      = 1'b0;

      // Table: one-cycle spike patterns drained with aer_ready held high.
      mon_en     = 1'b1;
      aer_ready  = 1'b1;
      merge_seen = 0;
      for (int v = 0; v < 7; v++) begin
         spike_in = tbl[v].spike;
         for (int k = 0; k < tbl[v].n; k++) sb.push_back(tbl[v].addrs[2*k +: 2]);
         tick();
         spike_in = '0;
         check("lat_pending", pending_any, 1);
         check("lat_cycle1",  aer_valid,   0);
         tick();
         check("lat_cycle2",  aer_valid,   1);
         beats = 0;
         while (aer_valid && beats < 20) begin
            tick();
            beats++;
         end
         check("beat_count", beats, tbl[v].n);
         wait_drain("table", 20);
      end
      check("table_no_merge", merge_seen, 0);
      check("table_drop",     drop_count, 0);

      // Backpressure: 12 events against an 8-deep FIFO, then drain.
      apply_reset(2);
      aer_ready  = 1'b0;
      merge_seen = 0;
      repeat (3) begin
         spike_in = 4'b1111;
         push_batch();
         tick();
         spike_in = '0;
         repeat (5) tick();
      end
      check("bp_level",    fifo_level,  8);
      check("bp_pending",  pending_any, 1);
      check("bp_no_merge", merge_seen,  0);
      aer_ready = 1'b1;
      wait_drain("bp", 40);

      // Merge: node 1 spikes on two consecutive cycles while the FIFO is full.
      apply_reset(2);
      aer_ready = 1'b0;
      repeat (2) begin
         spike_in = 4'b1111;
         push_batch();
         tick();
         spike_in = '0;
         repeat (5) tick();
      end
      check("merge_full", fifo_level, 8);
      merge_seen = 0;
      spike_in   = 4'b0010;
      sb.push_back(AW'(1));
      tick();
      check("merge_not_yet", merge_pulse, 0);
      tick();
      spike_in = '0;
      repeat (4) tick();
      check("merge_pulses",  merge_seen,  1);
      check("merge_pending", pending_any, 1);
      check("merge_drop",    drop_count,  exp_drop);
      aer_ready = 1'b1;
      wait_drain("merge", 40);
      check("merge_drop_hold", drop_count, exp_drop);

      // Mid-stream reset with five queued events.
      apply_reset(2);
      mon_en    = 1'b0;
      aer_ready = 1'b0;
      spike_in  = 4'b1111;
      tick();
      spike_in = '0;
      repeat (5) tick();
      spike_in = 4'b0001;
      tick();
      spike_in = '0;
      repeat (3) tick();
      check("mid_level5", fifo_level, 5);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      sb.delete();
      check("mid_valid",   aer_valid,   0);
      check("mid_level",   fifo_level,  0);
      check("mid_pending", pending_any, 0);
      mon_en    = 1'b1;
      aer_ready = 1'b1;
      c = 0;
      repeat (10) begin
         tick();
         if (aer_valid) c++;
      end
      check("mid_no_stale", c, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
